// File: rtl/iq_decim_axis.sv
// iq_decim_axis: keeps one of every DECIM strobed I/Q samples, packs each
// kept pair as {Q,I}, buffers the words in a first-word-fall-through FIFO
// and presents them as an AXI4-Stream master. It also reports a sticky
// overflow flag and the FIFO fill level.
module iq_decim_axis #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          ce,
    input  logic                          strobe_in,
    input  logic [DATA_WIDTH-1:0]         I_in,
    input  logic [DATA_WIDTH-1:0]         Q_in,
    input  logic                          clr_ovf,
    output logic [2*DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FW     = AW + 1;
    localparam int WW     = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);
    localparam logic [FW-1:0]    FULL_LVL = FW'(FIFO_DEPTH);

    // Architectural state
    logic [CNT_W-1:0] cnt_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [FW-1:0]    fill_r;
    logic             valid_r;
    logic [WW-1:0]    tdata_r;
    logic             ovf_r;
    logic [WW-1:0]    mem_r [FIFO_DEPTH];

    // Next-state and qualifier signals
    logic             accept_s;
    logic             keep_s;
    logic             rd_s;
    logic             full_s;
    logic             wr_s;
    logic             drop_s;
    logic [WW-1:0]    din_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [FW-1:0]    fill_nxt_s;
    logic [WW-1:0]    tdata_nxt_s;
    logic             ovf_nxt_s;

    // Decode input acceptance, decimation and FIFO write/read for this cycle
    always_comb begin
        accept_s     = ce & strobe_in;
        keep_s       = 1'b0;
        cnt_nxt_s    = cnt_r;
        din_s        = {Q_in, I_in};
        rd_s         = valid_r & m_axis_tready;
        full_s       = (fill_r == FULL_LVL);
        if (accept_s) begin
            if (cnt_r == LAST_CNT) begin
                keep_s    = 1'b1;
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // A full FIFO still takes the word when the head leaves this cycle.
        wr_s   = keep_s & (~full_s | rd_s);
        drop_s = keep_s & full_s & ~rd_s;
    end

    // Compute pointer, fill, head-word and overflow next values
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        fill_nxt_s   = fill_r;
        ovf_nxt_s    = ovf_r;
        if (wr_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_s, rd_s})
            2'b10:   fill_nxt_s = fill_r + FW'(1);
            2'b01:   fill_nxt_s = fill_r - FW'(1);
            default: fill_nxt_s = fill_r;
        endcase
        // The head word is registered; when the slot being written becomes
        // the head (FIFO empty after this cycle's read), forward the input.
        if (wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            tdata_nxt_s = din_s;
        end else begin
            tdata_nxt_s = mem_r[rd_ptr_nxt_s];
        end
        // A new drop beats a simultaneous clear.
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
            valid_r  <= 1'b0;
            tdata_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            fill_r   <= fill_nxt_s;
            valid_r  <= (fill_nxt_s != '0);
            tdata_r  <= tdata_nxt_s;
            ovf_r    <= ovf_nxt_s;
        end
    end

    // FIFO storage; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= din_s;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = valid_r;
    assign fill          = fill_r;
    assign overflow      = ovf_r;

endmodule

// File: tb/tb_iq_decim_axis.sv
// Directed testbench for iq_decim_axis with DATA_WIDTH=16, DECIM=4,
// FIFO_DEPTH=16. Inputs change 1 ns after each rising edge and outputs are
// sampled at that same point, i.e. reflecting the edge just taken.
module tb_iq_decim_axis;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          ce;
    logic          strobe_in;
    logic [DW-1:0] I_in;
    logic [DW-1:0] Q_in;
    logic          clr_ovf;
    logic [2*DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [4:0]    fill;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    iq_decim_axis #(.DATA_WIDTH(DW), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .ce           (ce),
        .strobe_in    (strobe_in),
        .I_in         (I_in),
        .Q_in         (Q_in),
        .clr_ovf      (clr_ovf),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .fill         (fill),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int q, input int i);
        return {q[15:0], i[15:0]};
    endfunction

    task automatic drive(input logic s, input logic c, input int i, input int q);
        strobe_in = s;
        ce        = c;
        I_in      = i[15:0];
        Q_in      = q[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0; clr_ovf = 1'b0; m_axis_tready = 1'b0;
        drive(1'b0, 1'b0, 0, 0);

        // Reset held with random inputs
        for (int k = 0; k < 5; k++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom), int'($urandom));
            m_axis_tready = 1'($urandom_range(1));
            tick();
            check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("rst_fill", 32'(fill), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
        end
        aresetn = 1'b1;
        drive(1'b0, 1'b1, 0, 0);
        m_axis_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("idle_fill", 32'(fill), 32'd0);
            check("idle_ovf", 32'(overflow), 32'd0);
        end

        // Decimation: strobe every 4th cycle, I=k, Q=-k
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 1'b1, k, -k);
            tick();
            if (k % 4 == 0) begin
                check("dec_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("dec_tdata", m_axis_tdata, pack(-k, k));
                check("dec_fill", 32'(fill), 32'd1);
            end else begin
                check("dec_novalid", 32'(m_axis_tvalid), 32'd0);
            end
            drive(1'b0, 1'b1, 0, 0);
            for (int j = 0; j < 3; j++) tick();
            check("dec_drained", 32'(m_axis_tvalid), 32'd0);
        end

        // ce gating: strobes 1..10, ce low on 2 and 3; 4th/8th accepted = 6, 10
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, (k != 2 && k != 3), 100 + k, k);
            tick();
            if (k == 6 || k == 10) begin
                check("ce_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("ce_tdata", m_axis_tdata, pack(k, 100 + k));
            end else begin
                check("ce_novalid", 32'(m_axis_tvalid), 32'd0);
            end
            drive(1'b0, 1'b1, 0, 0);
            tick();
        end

        // Backpressure: 80 back-to-back strobes = 20 kept, I=k, Q=k+1000
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            drive(1'b1, 1'b1, k, k + 1000);
            tick();
            if (k == 64) begin
                check("bp_fill16", 32'(fill), 32'd16);
                check("bp_ovf_clear", 32'(overflow), 32'd0);
            end
            if (k == 68) begin
                check("bp_fill_sat", 32'(fill), 32'd16);
                check("bp_ovf_set", 32'(overflow), 32'd1);
            end
            if (k % 16 == 4) check("bp_tdata_hold", m_axis_tdata, pack(1004, 4));
        end
        check("bp_fill_end", 32'(fill), 32'd16);
        check("bp_ovf_end", 32'(overflow), 32'd1);
        check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);

        // Clear overflow, then a kept sample at full with a handshake
        drive(1'b0, 1'b1, 0, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int k = 81; k <= 84; k++) begin
            drive(1'b1, 1'b1, k, k + 1000);
            m_axis_tready = (k == 84);
            tick();
        end
        m_axis_tready = 1'b0;
        check("fullrd_fill", 32'(fill), 32'd16);
        check("fullrd_ovf", 32'(overflow), 32'd0);
        check("fullrd_head", m_axis_tdata, pack(1008, 8));

        // Drop coinciding with clr_ovf: set wins
        for (int k = 85; k <= 88; k++) begin
            drive(1'b1, 1'b1, k, k + 1000);
            clr_ovf = (k == 88);
            tick();
        end
        clr_ovf = 1'b0;
        drive(1'b0, 1'b1, 0, 0);
        check("clr_vs_drop", 32'(overflow), 32'd1);
        check("drop_fill", 32'(fill), 32'd16);

        // Drain: words I=8,12,..,64 then 84
        m_axis_tready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            int ei;
            ei = (n < 15) ? 8 + 4 * n : 84;
            check("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("drain_tdata", m_axis_tdata, pack(ei + 1000, ei));
            tick();
        end
        check("drain_empty", 32'(m_axis_tvalid), 32'd0);
        check("drain_fill", 32'(fill), 32'd0);

        // Reset mid-operation with 5 words buffered
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b1, k, k);
            tick();
        end
        drive(1'b0, 1'b0, 0, 0);
        check("mid_fill5", 32'(fill), 32'd5);
        aresetn = 1'b0;
        #1;
        check("async_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("async_fill", 32'(fill), 32'd0);
        tick();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 200 + k, -(200 + k));
            tick();
            if (k == 4) begin
                check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("post_rst_tdata", m_axis_tdata, pack(-204, 204));
            end else begin
                check("post_rst_novalid", 32'(m_axis_tvalid), 32'd0);
            end
        end
        drive(1'b0, 1'b1, 0, 0);
        tick();
        check("post_rst_drain", 32'(m_axis_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
